// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared bus/memory definitions for the processor-memory port and the types
// used by the arbiter between the data cache and the instruction cache.
//   BUS_COMMAND  : memory bus command (none / load / store)
// MEM_SIZE     : access size carried with each request
// MEM_OWNER    : which requester owns an outstanding load tag
// ARB_GRANT    : arbiter grant decision for the current cycle
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    localparam int unsigned NUM_MEM_TAGS = 15;
    localparam int unsigned DATA_SIZE    = 64;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } MEM_OWNER;

    typedef enum logic [1:0] {
        GNT_NONE = 2'h0,
        GNT_D    = 2'h1,
        GNT_I    = 2'h2
    } ARB_GRANT;

endpackage

// File: rtl/mem_bus_arbiter_tag_table.sv
// -----------------------------------------------------------------------------
// mem_tag_table
// Owner table for outstanding memory load tags. One entry per tag value,
// each holding {valid, owner}. Entry 0 ("no tag") is never written.
//   i_clock, i_reset  : clock, asynchronous active-high reset
// i_set_en/_tag/_owner : record a newly accepted load tag and its owner
//   i_clr_en/_tag     : retire a completed tag
//   i_lkp_tag         : combinational lookup index
//   o_lkp_valid/_owner: lookup result
// A set and a clear of the same tag in one cycle leaves the entry valid with
// the new owner (tag retired and reissued in the same cycle).
// -----------------------------------------------------------------------------
module mem_tag_table
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TW = 4
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_set_en,
    input  logic [TW-1:0] i_set_tag,
    input  MEM_OWNER      i_set_owner,
    input  logic          i_clr_en,
    input  logic [TW-1:0] i_clr_tag,
    input  logic [TW-1:0] i_lkp_tag,
    output logic          o_lkp_valid,
    output MEM_OWNER      o_lkp_owner
);

    localparam int unsigned NE = 2 ** TW;

    logic [NE-1:0] r_valid;
    MEM_OWNER      r_owner [NE];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= '0;
            for (int e = 0; e < NE; e++) begin
                r_owner[e] <= OWN_D;
            end
        end else begin
            // Loop starts at 1 so entry 0 stays invalid forever.
            for (int e = 1; e < NE; e++) begin
                if (i_set_en && (i_set_tag == TW'(e))) begin
                    r_valid[e] <= 1'b1;
                    r_owner[e] <= i_set_owner;
                end else if (i_clr_en && (i_clr_tag == TW'(e))) begin
                    r_valid[e] <= 1'b0;
                end
            end
        end
    end

    assign o_lkp_valid = r_valid[i_lkp_tag];
    assign o_lkp_owner = r_owner[i_lkp_tag];

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares the single processor-memory port between the data cache (D) and the
// instruction cache (I). D has priority; an age counter (wait_cnt) hands the
// port to I after IC_MAX_WAIT consecutive rejected I cycles. Accepted load
// tags are recorded with their owner so returning data is steered only to the
// requester that issued the load.
//   clock, reset                  : clock, asynchronous active-high reset
//   d_command/addr/data/size      : data-cache request
//   i_command/addr/size           : I-cache request (loads only)
//   mem2proc_response/data/tag    : memory acceptance tag and return data
//   proc2mem_command/addr/data/size : request forwarded to memory
//   d_response/rdata/tag          : acceptance and completion to data cache
//   i_response/rdata/tag          : acceptance and completion to I-cache
//   tag_err                       : sticky, returned tag had no owner
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TW          = $clog2(NUM_MEM_TAGS),
    parameter int unsigned IC_MAX_WAIT = 4
) (
    input  logic                 clock,
    input  logic                 reset,

    input  BUS_COMMAND           d_command,
    input  logic [31:0]          d_addr,
    input  logic [DATA_SIZE-1:0] d_data,
    input  MEM_SIZE              d_size,

    input  BUS_COMMAND           i_command,
    input  logic [31:0]          i_addr,
    input  MEM_SIZE              i_size,

    input  logic [TW-1:0]        mem2proc_response,
    input  logic [DATA_SIZE-1:0] mem2proc_data,
    input  logic [TW-1:0]        mem2proc_tag,

    output BUS_COMMAND           proc2mem_command,
    output logic [31:0]          proc2mem_addr,
    output logic [DATA_SIZE-1:0] proc2mem_data,
    output MEM_SIZE              proc2mem_size,

    output logic [TW-1:0]        d_response,
    output logic [DATA_SIZE-1:0] d_rdata,
    output logic [TW-1:0]        d_tag,

    output logic [TW-1:0]        i_response,
    output logic [DATA_SIZE-1:0] i_rdata,
    output logic [TW-1:0]        i_tag,

    output logic                 tag_err
);

    localparam int unsigned WCW = $clog2(IC_MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(IC_MAX_WAIT);

    logic [WCW-1:0] r_wait_cnt;
    logic           r_tag_err;

    logic           w_d_req;
    logic           w_i_req;
    ARB_GRANT       w_grant;
    logic           w_accepted;
    logic           w_i_accept;
    logic           w_set_en;
    MEM_OWNER       w_set_owner;
    logic           w_tag_present;
    logic           w_lkp_valid;
    MEM_OWNER       w_lkp_owner;
    logic           w_hit;
    logic           w_orphan;

    assign w_d_req = (d_command != BUS_NONE);
    assign w_i_req = (i_command != BUS_NONE);

    // Grant: a starved I-cache overrides D priority.
    always_comb begin
        w_grant = GNT_NONE;
        if (w_i_req && (r_wait_cnt == WAIT_MAX)) begin
            w_grant = GNT_I;
        end else if (w_d_req) begin
            w_grant = GNT_D;
        end else if (w_i_req) begin
            w_grant = GNT_I;
        end
    end

    // Request forwarding and acceptance routing.
    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        proc2mem_size    = BYTE;
        d_response       = '0;
        i_response       = '0;
        unique case (w_grant)
            GNT_D: begin
                proc2mem_command = d_command;
                proc2mem_addr    = d_addr;
                proc2mem_data    = d_data;
                proc2mem_size    = d_size;
                d_response       = mem2proc_response;
            end
            GNT_I: begin
                proc2mem_command = i_command;
                proc2mem_addr    = i_addr;
                proc2mem_size    = i_size;
                i_response       = mem2proc_response;
            end
            default: ;
        endcase
    end

    assign w_accepted  = (mem2proc_response != '0);
    assign w_i_accept  = (w_grant == GNT_I) && w_accepted;
    // Stores complete without a tag return, so only loads are tracked.
    assign w_set_en    = (proc2mem_command == BUS_LOAD) && w_accepted;
    assign w_set_owner = (w_grant == GNT_I) ? OWN_I : OWN_D;

    assign w_tag_present = (mem2proc_tag != '0);
    assign w_hit         = w_tag_present && w_lkp_valid;
    assign w_orphan      = w_tag_present && !w_lkp_valid;

    mem_tag_table #(
        .TW (TW)
    ) u_tag_table (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_set_en    (w_set_en),
        .i_set_tag   (mem2proc_response),
        .i_set_owner (w_set_owner),
        .i_clr_en    (w_hit),
        .i_clr_tag   (mem2proc_tag),
        .i_lkp_tag   (mem2proc_tag),
        .o_lkp_valid (w_lkp_valid),
        .o_lkp_owner (w_lkp_owner)
    );

    // Completion steering: only the recorded owner sees the tag and data.
    always_comb begin
        d_tag   = '0;
        d_rdata = '0;
        i_tag   = '0;
        i_rdata = '0;
        if (w_hit) begin
            if (w_lkp_owner == OWN_I) begin
                i_tag   = mem2proc_tag;
                i_rdata = mem2proc_data;
            end else begin
                d_tag   = mem2proc_tag;
                d_rdata = mem2proc_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (w_i_accept || !w_i_req) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != WAIT_MAX) begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tag_err <= 1'b0;
        end else if (w_orphan) begin
            r_tag_err <= 1'b1;
        end
    end

    assign tag_err = r_tag_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: each cycle the driver applies inputs just after the rising
// edge and queues the hand-computed outputs; the monitor pops and compares on
// the falling edge.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int unsigned TW = 4;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    BUS_COMMAND           d_command = BUS_NONE;
    logic [31:0]          d_addr = '0;
    logic [DATA_SIZE-1:0] d_data = '0;
    MEM_SIZE              d_size = DOUBLE;
    BUS_COMMAND           i_command = BUS_NONE;
    logic [31:0]          i_addr = '0;
    MEM_SIZE              i_size = WORD;
    logic [TW-1:0]        mem2proc_response = '0;
    logic [DATA_SIZE-1:0] mem2proc_data = '0;
    logic [TW-1:0]        mem2proc_tag = '0;
    BUS_COMMAND           proc2mem_command;
    logic [31:0]          proc2mem_addr;
    logic [DATA_SIZE-1:0] proc2mem_data;
    MEM_SIZE              proc2mem_size;
    logic [TW-1:0]        d_response, d_tag, i_response, i_tag;
    logic [DATA_SIZE-1:0] d_rdata, i_rdata;
    logic                 tag_err;

    mem_bus_arbiter #(
        .TW          (TW),
        .IC_MAX_WAIT (4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .d_command         (d_command),
        .d_addr            (d_addr),
        .d_data            (d_data),
        .d_size            (d_size),
        .i_command         (i_command),
        .i_addr            (i_addr),
        .i_size            (i_size),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .proc2mem_size     (proc2mem_size),
        .d_response        (d_response),
        .d_rdata           (d_rdata),
        .d_tag             (d_tag),
        .i_response        (i_response),
        .i_rdata           (i_rdata),
        .i_tag             (i_tag),
        .tag_err           (tag_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        string         nm;
        BUS_COMMAND    cmd;
        logic [31:0]   addr;
        logic [63:0]   pdata;
        MEM_SIZE       size;
        logic [TW-1:0] dresp;
        logic [TW-1:0] iresp;
        logic [TW-1:0] dtag;
        logic [63:0]   drdata;
        logic [TW-1:0] itag;
        logic [63:0]   irdata;
        logic          terr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string nm, input string fld,
                       input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s.%s got %h want %h", nm, fld, act, want);
        end
    endtask

    task automatic drv(input logic rst, input BUS_COMMAND dc, input logic [31:0] da,
                       input logic [63:0] dd, input BUS_COMMAND ic, input logic [31:0] ia,
                       input logic [TW-1:0] resp, input logic [TW-1:0] mtag,
                       input logic [63:0] mdata);
        @(posedge clock);
        #1;
        reset             = rst;
        d_command         = dc;
        d_addr            = da;
        d_data            = dd;
        i_command         = ic;
        i_addr            = ia;
        mem2proc_response = resp;
        mem2proc_tag      = mtag;
        mem2proc_data     = mdata;
    endtask

    task automatic exp_out(input string nm, input BUS_COMMAND cmd, input logic [31:0] addr,
                           input logic [63:0] pdata, input MEM_SIZE size,
                           input logic [TW-1:0] dresp, input logic [TW-1:0] iresp,
                           input logic [TW-1:0] dtag, input logic [63:0] drdata,
                           input logic [TW-1:0] itag, input logic [63:0] irdata,
                           input logic terr);
        exp_t e;
        e.nm = nm; e.cmd = cmd; e.addr = addr; e.pdata = pdata; e.size = size;
        e.dresp = dresp; e.iresp = iresp; e.dtag = dtag; e.drdata = drdata;
        e.itag = itag; e.irdata = irdata; e.terr = terr;
        exp_q.push_back(e);
    endtask

    // Monitor: compares the queued expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.nm, "cmd",    64'(proc2mem_command), 64'(e.cmd));
                chk(e.nm, "addr",   64'(proc2mem_addr),    64'(e.addr));
                chk(e.nm, "pdata",  proc2mem_data,         e.pdata);
                chk(e.nm, "size",   64'(proc2mem_size),    64'(e.size));
                chk(e.nm, "dresp",  64'(d_response),       64'(e.dresp));
                chk(e.nm, "iresp",  64'(i_response),       64'(e.iresp));
                chk(e.nm, "dtag",   64'(d_tag),            64'(e.dtag));
                chk(e.nm, "drdata", d_rdata,               e.drdata);
                chk(e.nm, "itag",   64'(i_tag),            64'(e.itag));
                chk(e.nm, "irdata", i_rdata,               e.irdata);
                chk(e.nm, "tagerr", 64'(tag_err),          64'(e.terr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, no requests.
        drv(1, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0);
        exp_out("reset", BUS_NONE, 0, 0, BYTE, 0, 0, 0, 0, 0, 0, 0);

        // D load, then its completion, then stale return of the retired tag.
        drv(0, BUS_LOAD, 32'h100, 0, BUS_NONE, 0, 3, 0, 0);
        exp_out("d_ld3", BUS_LOAD, 32'h100, 0, DOUBLE, 3, 0, 0, 0, 0, 0, 0);
        drv(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 3, 64'hDEAD);
        exp_out("d_cpl3", BUS_NONE, 0, 0, BYTE, 0, 0, 3, 64'hDEAD, 0, 0, 0);
        drv(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 3, 64'h77);
        exp_out("stale3", BUS_NONE, 0, 0, BYTE, 0, 0, 0, 0, 0, 0, 0);
        drv(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0);
        exp_out("terr_set", BUS_NONE, 0, 0, BYTE, 0, 0, 0, 0, 0, 0, 1);
        drv(1, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0);
        exp_out("rst_clr", BUS_NONE, 0, 0, BYTE, 0, 0, 0, 0, 0, 0, 0);

        // D priority, then I alone, then completions to each owner.
        drv(0, BUS_LOAD, 32'h200, 0, BUS_LOAD, 32'h300, 5, 0, 0);
        exp_out("both", BUS_LOAD, 32'h200, 0, DOUBLE, 5, 0, 0, 0, 0, 0, 0);
        drv(0, BUS_NONE, 0, 0, BUS_LOAD, 32'h300, 6, 0, 0);
        exp_out("i_only", BUS_LOAD, 32'h300, 0, WORD, 0, 6, 0, 0, 0, 0, 0);
        drv(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 6, 64'hBEEF);
        exp_out("i_cpl6", BUS_NONE, 0, 0, BYTE, 0, 0, 0, 0, 6, 64'hBEEF, 0);
        drv(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 5, 64'h55);
        exp_out("d_cpl5", BUS_NONE, 0, 0, BYTE, 0, 0, 5, 64'h55, 0, 0, 0);

        // Starvation: I rejected four times, granted on the fifth cycle.
        for (int k = 0; k < 4; k++) begin
            drv(0, BUS_LOAD, 32'h400, 0, BUS_LOAD, 32'h500, 1, 0, 0);
            exp_out("starve", BUS_LOAD, 32'h400, 0, DOUBLE, 1, 0, 0, 0, 0, 0, 0);
        end
        drv(0, BUS_LOAD, 32'h400, 0, BUS_LOAD, 32'h500, 8, 0, 0);
        exp_out("ic_prio", BUS_LOAD, 32'h500, 0, WORD, 0, 8, 0, 0, 0, 0, 0);
        drv(0, BUS_LOAD, 32'h400, 0, BUS_LOAD, 32'h500, 9, 0, 0);
        exp_out("d_again", BUS_LOAD, 32'h400, 0, DOUBLE, 9, 0, 0, 0, 0, 0, 0);
        drv(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 8, 64'h88);
        exp_out("i_cpl8", BUS_NONE, 0, 0, BYTE, 0, 0, 0, 0, 8, 64'h88, 0);
        drv(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 1, 64'h11);
        exp_out("d_cpl1", BUS_NONE, 0, 0, BYTE, 0, 0, 1, 64'h11, 0, 0, 0);
        drv(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 9, 64'h99);
        exp_out("d_cpl9", BUS_NONE, 0, 0, BYTE, 0, 0, 9, 64'h99, 0, 0, 0);

        // Store acceptance is not recorded; its tag return is an orphan.
        drv(0, BUS_STORE, 32'h600, 64'h1234_5678, BUS_NONE, 0, 2, 0, 0);
        exp_out("d_st2", BUS_STORE, 32'h600, 64'h1234_5678, DOUBLE, 2, 0, 0, 0, 0, 0, 0);
        drv(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 2, 64'h22);
        exp_out("st_ret", BUS_NONE, 0, 0, BYTE, 0, 0, 0, 0, 0, 0, 0);
        drv(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0);
        exp_out("st_terr", BUS_NONE, 0, 0, BYTE, 0, 0, 0, 0, 0, 0, 1);

        // Tag 4 completes and is reissued in one cycle: set wins.
        drv(0, BUS_NONE, 0, 0, BUS_LOAD, 32'h700, 4, 0, 0);
        exp_out("i_ld4", BUS_LOAD, 32'h700, 0, WORD, 0, 4, 0, 0, 0, 0, 1);
        drv(0, BUS_NONE, 0, 0, BUS_LOAD, 32'h704, 4, 4, 64'hAAAA);
        exp_out("reuse4", BUS_LOAD, 32'h704, 0, WORD, 0, 4, 0, 0, 4, 64'hAAAA, 1);
        drv(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4, 64'hBBBB);
        exp_out("ret4", BUS_NONE, 0, 0, BYTE, 0, 0, 0, 0, 4, 64'hBBBB, 1);
        drv(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4, 64'hCCCC);
        exp_out("gone4", BUS_NONE, 0, 0, BYTE, 0, 0, 0, 0, 0, 0, 1);

        // Three outstanding loads, then asynchronous reset mid-cycle.
        drv(0, BUS_LOAD, 32'h800, 0, BUS_NONE, 0, 10, 0, 0);
        exp_out("ld10", BUS_LOAD, 32'h800, 0, DOUBLE, 10, 0, 0, 0, 0, 0, 1);
        drv(0, BUS_NONE, 0, 0, BUS_LOAD, 32'h804, 11, 0, 0);
        exp_out("ld11", BUS_LOAD, 32'h804, 0, WORD, 0, 11, 0, 0, 0, 0, 1);
        drv(0, BUS_LOAD, 32'h808, 0, BUS_NONE, 0, 12, 0, 0);
        exp_out("ld12", BUS_LOAD, 32'h808, 0, DOUBLE, 12, 0, 0, 0, 0, 0, 1);
        drv(1, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 10, 64'h1010);
        exp_out("rst_mid", BUS_NONE, 0, 0, BYTE, 0, 0, 0, 0, 0, 0, 0);
        drv(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 11, 64'h1111);
        exp_out("post_rst", BUS_NONE, 0, 0, BYTE, 0, 0, 0, 0, 0, 0, 0);
        drv(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0);
        exp_out("post_terr", BUS_NONE, 0, 0, BYTE, 0, 0, 0, 0, 0, 0, 1);

        // Let the monitor drain the queue, bounded.
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            @(posedge clock);
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single processor–memory port between the data-cache side (`dcache_top`) and the instruction cache. Each cycle it grants the memory port to one requester. The data cache has priority, and an age counter guarantees the instruction cache makes forward progress. The block records which requester owns each outstanding load tag and steers returning memory data to that requester only.

## Interface
Parameters:
- `TW`, default `$clog2(`NUM_MEM_TAGS)`: memory tag width. Tag 0 means "no tag".
- `IC_MAX_WAIT`, default 4: consecutive rejected I-cache cycles before the I-cache gets priority.

Ports:
- `clock`  in  1: single clock for the whole block.
- `reset`  in  1: asynchronous, active-high.
- `d_command` / `d_addr` / `d_data` / `d_size`  in  BUS_COMMAND / 32 / `DATA_SIZE` / MEM_SIZE: data-cache request.
- `i_command` / `i_addr` / `i_size`  in  BUS_COMMAND / 32 / MEM_SIZE: I-cache request. I-cache issues loads only.
- `mem2proc_response` / `mem2proc_data` / `mem2proc_tag`  in  TW / `DATA_SIZE` / TW: memory return.
- `proc2mem_command` / `proc2mem_addr` / `proc2mem_data` / `proc2mem_size`  out  BUS_COMMAND / 32 / `DATA_SIZE` / MEM_SIZE: to memory.
- `d_response` / `d_rdata` / `d_tag`  out  TW / `DATA_SIZE` / TW: to data cache.
- `i_response` / `i_rdata` / `i_tag`  out  TW / `DATA_SIZE` / TW: to I-cache.
- `tag_err`  out  1: sticky flag. Set when memory returns a tag with no recorded owner.

## Operation
- Grant (combinational):
  - If `wait_cnt == IC_MAX_WAIT` and `i_command != BUS_NONE`, grant I-cache.
  - Otherwise grant D-cache if `d_command != BUS_NONE`.
  - Otherwise grant I-cache if it is requesting.
  - Otherwise grant nobody: command BUS_NONE, addr/data 0.
- Granted requester's fields drive `proc2mem_*`. `proc2mem_data` is `d_data` for a D grant and 0 otherwise.
- `mem2proc_response` goes to the granted side's `*_response`. The other side's `*_response` is 0.
  - A non-granted requester sees 0, i.e. "rejected, retry".
- Owner table: 2^TW entries of {valid, owner∈{D,I}}. Entry 0 is never written.
  - On a clock edge where the granted command is BUS_LOAD and `mem2proc_response != 0`, entry[response] ← {1, grantee}.
  - BUS_STORE acceptances are not recorded.
- Completion: when `mem2proc_tag != 0` and entry[tag].valid:
  - Drive `<owner>_tag = mem2proc_tag` and `<owner>_rdata = mem2proc_data`. The other side's tag is 0.
  - Clear the entry at the edge.
- If `mem2proc_tag != 0` and the entry is invalid: data is dropped, both `*_tag` stay 0, and `tag_err` sets at the next edge. It clears only on reset.
- Same tag completing and being reissued in one cycle: the set wins and the entry stays valid with the new owner.
- `wait_cnt`:
  - Resets to 0 when the I-cache command is accepted (granted and response ≠ 0) or `i_command == BUS_NONE`.
  - Otherwise increments, saturating at `IC_MAX_WAIT`.
- `*_rdata` is 0 whenever the corresponding `*_tag` is 0.

## Timing
- Grant, request forwarding, response routing and completion steering are all combinational, with zero added latency.
- The owner table, `wait_cnt` and `tag_err` update on `posedge clock`.
- Reset is asynchronous. While `reset` is high and after it:
  - All table entries are invalid, `wait_cnt` = 0, `tag_err` = 0.
  - With no requests, every output is 0 / BUS_NONE.
- Reset mid-operation discards all outstanding ownership. Tags returning after reset raise `tag_err`. The system resets memory together with this block, so this is a test-only case.

## Structure
- BUS_COMMAND, MEM_SIZE, `NUM_MEM_TAGS` and `DATA_SIZE` come from the shared `sys_defs` package/header.
- Add `typedef enum logic {OWN_D, OWN_I} MEM_OWNER` to the shared package.
- One natural sub-module: `mem_tag_table` (owner table with a set port, a clear port and a lookup port, set-over-clear priority).
- Grant logic and `wait_cnt` live in the top module.

## Test plan
- D load to 0x100, memory responds 3; later `mem2proc_tag` = 3, data 0xDEAD → `d_tag` = 3, `d_rdata` = 0xDEAD, `i_tag` = 0, entry 3 cleared.
- D and I load together, response 5 → D granted, `d_response` = 5, `i_response` = 0. Next cycle I alone, response 6 → `i_response` = 6. Tag 6 returns → `i_tag` = 6.
- D requesting every cycle, I requesting continuously → I granted on cycle 5 (`wait_cnt` reached 4), `wait_cnt` back to 0.
- D store accepted with response 2, then `mem2proc_tag` = 2 → no `*_tag` asserted, `tag_err` = 1.
- Tag 4 completes for I while an I load is accepted with new tag 4 in the same cycle → entry 4 stays valid with owner I. The next return of tag 4 goes to I.
- Reset asserted asynchronously mid-cycle with 3 outstanding loads → all entries invalid immediately. Outputs are 0 with no requests.
